// File: rtl/ddr_test_pkg.sv
// Shared types and constants for the DDR read-test checker.
// Holds AXI response codes, checker FSM states and command width helpers.
package ddr_test_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_ADDR_W = 32;
  localparam int LEN_W      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  function automatic int cmd_w(input int aw);
    return aw + LEN_W;
  endfunction

  localparam int CMD_W = DEF_ADDR_W + LEN_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
  } rd_cmd_t;

endpackage

// File: rtl/ddr_rd_cmd_fifo.sv
// Outstanding AR command queue for the read checker.
// First-word-fall-through: dout always shows the head entry.
module ddr_rd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  logic w_push;
  logic w_pop;

  assign full  = (r_cnt == FULL_CNT);
  assign empty = (r_cnt == '0);
  assign dout  = r_mem[r_rd];

  // a pop frees the head slot, so a full queue can still take a push
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ddr_rd_checker.sv
// DDR read-path checker: snoops AR, owns rready, checks each R beat
// against an address-derived pattern and keeps bring-up statistics.
module ddr_rd_checker
  import ddr_test_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          CMD_DEPTH = 4,
  parameter logic [31:0] SEED      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  input  logic              arready,
  output logic              cmd_full,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              err_flag,
  output logic              resp_err,
  output logic              last_err,
  output logic              ovf_err,
  output logic              idle
);

  localparam int CW = cmd_w(ADDR_W);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W/8);
  localparam logic [ADDR_W+31:0] SEED_X = {{ADDR_W{1'b0}}, SEED};
  localparam logic [ADDR_W-1:0] SEED_A = SEED_X[ADDR_W-1:0];

  rd_state_e r_state;
  rd_state_e w_nxt;

  logic [ADDR_W-1:0] r_cur_addr;
  logic [7:0]        r_cur_rem;
  logic [31:0]       r_beat_cnt;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_ferr_addr;
  logic [DATA_W-1:0] r_ferr_data;
  logic              r_err_flag;
  logic              r_resp_err;
  logic              r_last_err;
  logic              r_ovf_err;
  logic              r_idle;

  logic [CW-1:0]     w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf;
  logic              w_beat;
  logic              w_rem_zero;
  logic              w_end;
  logic              w_last_bad;
  logic              w_mis;
  logic [ADDR_W-1:0] w_pat;
  logic [ADDR_W+DATA_W-1:0] w_pat_ext;
  logic [DATA_W-1:0] w_exp;

  assign w_push = arvalid & arready;
  assign w_pop  = (r_state == IDLE) & ~w_empty;
  assign w_ovf  = w_push & w_full & ~w_pop;

  ddr_rd_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({araddr, arlen}),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rready = (r_state == BURST);
  assign w_beat = rvalid & rready;

  assign w_rem_zero = (r_cur_rem == 8'd0);
  assign w_end      = w_beat & (w_rem_zero | rlast);
  assign w_last_bad = w_beat & (w_rem_zero ^ rlast);

  // pattern is zero-extended or truncated to the data bus width
  assign w_pat     = r_cur_addr ^ SEED_A;
  assign w_pat_ext = {{DATA_W{1'b0}}, w_pat};
  assign w_exp     = w_pat_ext[DATA_W-1:0];
  assign w_mis     = w_beat & (rdata != w_exp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pop) w_nxt = BURST;
      BURST:   if (w_end) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cur_addr <= '0;
      r_cur_rem  <= '0;
    end else if (w_pop) begin
      r_cur_addr <= w_dout[CW-1:8];
      r_cur_rem  <= w_dout[7:0];
    end else if (w_beat) begin
      r_cur_addr <= r_cur_addr + STRIDE;
      if (!w_rem_zero) r_cur_rem <= r_cur_rem - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
      r_err_flag  <= 1'b0;
      r_resp_err  <= 1'b0;
      r_last_err  <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else if (clr) begin
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
      r_err_flag  <= 1'b0;
      r_resp_err  <= 1'b0;
      r_last_err  <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      if (w_beat && r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 32'd1;
      if (w_mis) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
        r_err_flag <= 1'b1;
        if (!r_err_flag) begin
          r_ferr_addr <= r_cur_addr;
          r_ferr_data <= rdata;
        end
      end
      if (w_beat && rresp != RESP_OKAY) r_resp_err <= 1'b1;
      if (w_last_bad) r_last_err <= 1'b1;
      if (w_ovf)      r_ovf_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_idle <= 1'b1;
    else       r_idle <= (r_state == IDLE) & w_empty;
  end

  assign cmd_full       = w_full;
  assign beat_cnt       = r_beat_cnt;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_ferr_addr;
  assign first_err_data = r_ferr_data;
  assign err_flag       = r_err_flag;
  assign resp_err       = r_resp_err;
  assign last_err       = r_last_err;
  assign ovf_err        = r_ovf_err;
  assign idle           = r_idle;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Directed bench for ddr_rd_checker with a per-beat expected-data queue
// filled on AR issue and drained as R beats are accepted.
module tb_ddr_rd_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready = 1'b0;
  logic        cmd_full;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] beat_cnt;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic [31:0] first_err_data;
  logic        err_flag;
  logic        resp_err;
  logic        last_err;
  logic        ovf_err;
  logic        idle;

  always #5 clk = ~clk;

  ddr_rd_checker dut (
    .clk            (clk),
    .rstn           (rstn),
    .clr            (clr),
    .araddr         (araddr),
    .arlen          (arlen),
    .arvalid        (arvalid),
    .arready        (arready),
    .cmd_full       (cmd_full),
    .rdata          (rdata),
    .rresp          (rresp),
    .rlast          (rlast),
    .rvalid         (rvalid),
    .rready         (rready),
    .beat_cnt       (beat_cnt),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .err_flag       (err_flag),
    .resp_err       (resp_err),
    .last_err       (last_err),
    .ovf_err        (ovf_err),
    .idle           (idle)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  beat_t exp_q[$];

  int total = 0;
  int bad = 0;

  logic [31:0] m_beats;
  logic [15:0] m_errs;
  logic [31:0] m_faddr;
  logic [31:0] m_fdata;
  logic        m_flag;
  logic        m_resp;
  logic        m_last;
  logic        m_ovf;

  task automatic model_clear();
    m_beats = '0;
    m_errs  = '0;
    m_faddr = '0;
    m_fdata = '0;
    m_flag  = 1'b0;
    m_resp  = 1'b0;
    m_last  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input int len);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.a = addr + 32'(4 * i);
      b.d = b.a;
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_ar(input logic [31:0] addr, input int len);
    araddr  = addr;
    arlen   = 8'(len);
    arvalid = 1'b1;
    arready = 1'b1;
    push_exp(addr, len);
    @(negedge clk);
    arvalid = 1'b0;
    arready = 1'b0;
  endtask

  task automatic wait_rready(input string tag, output bit ok);
    int n;
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = rready;
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL %s_timeout obs=0 exp=1", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  // drive nb beats of a burst of length len; leftover expectations dropped
  task automatic serve(input string tag, input int len, input int nb,
                       input int bad_idx, input int last_idx,
                       input logic [1:0] resp0);
    beat_t e;
    bit ok;
    logic [31:0] d;
    for (int b = 0; b < nb; b++) begin
      wait_rready(tag, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      d = (b == bad_idx) ? 32'hDEAD_BEEF : e.d;
      rdata  = d;
      rresp  = (b == 0) ? resp0 : 2'b00;
      rlast  = (b == last_idx);
      rvalid = 1'b1;
      if (m_beats != '1) m_beats++;
      if (d != e.d) begin
        if (m_errs != '1) m_errs++;
        if (!m_flag) begin
          m_faddr = e.a;
          m_fdata = d;
        end
        m_flag = 1'b1;
      end
      if (rresp != 2'b00) m_resp = 1'b1;
      if ((len - b == 0) != (b == last_idx)) m_last = 1'b1;
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    for (int i = nb; i <= len; i++) void'(exp_q.pop_front());
  endtask

  task automatic check_all(input string tag);
    wait_idle(tag);
    check({tag, "_beats"}, beat_cnt, m_beats);
    check({tag, "_errs"}, 32'(err_cnt), 32'(m_errs));
    check({tag, "_faddr"}, first_err_addr, m_faddr);
    check({tag, "_fdata"}, first_err_data, m_fdata);
    check({tag, "_eflag"}, 32'(err_flag), 32'(m_flag));
    check({tag, "_resp"}, 32'(resp_err), 32'(m_resp));
    check({tag, "_last"}, 32'(last_err), 32'(m_last));
    check({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    bit ok;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_full", 32'(cmd_full), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_beats", beat_cnt, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single beat
    issue_ar(32'h8100_0000, 0);
    serve("single", 0, 1, -1, 0, 2'b00);
    check_all("single");

    // 4-beat burst, beat 2 corrupted
    issue_ar(32'h8100_0010, 3);
    serve("burst4", 3, 4, 2, 3, 2'b00);
    check_all("burst4");
    check("burst4_faddr_abs", first_err_addr, 32'h8100_0018);
    check("burst4_fdata_abs", first_err_data, 32'hDEAD_BEEF);
    check("burst4_errs_abs", 32'(err_cnt), 32'd1);

    // early rlast on beat 1 of a 4-beat burst
    pulse_clr();
    issue_ar(32'h8100_0100, 3);
    serve("early", 3, 2, -1, 1, 2'b00);
    check("early_rready", 32'(rready), 32'd0);
    check_all("early");
    check("early_last_abs", 32'(last_err), 32'd1);

    // missing rlast on single beat
    pulse_clr();
    issue_ar(32'h8100_0200, 0);
    serve("nolast", 0, 1, -1, -1, 2'b00);
    check_all("nolast");

    // queue fill and overflow while one burst waits for data
    pulse_clr();
    issue_ar(32'h8200_0000, 1);
    wait_rready("ovf_pre", ok);
    arvalid = 1'b1;
    arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      araddr = 32'h8200_1000 + 32'(i * 32'h100);
      arlen  = 8'(i);
      if (i < 4) push_exp(araddr, i);
      @(negedge clk);
      if (i == 3) check("ovf_full", 32'(cmd_full), 32'd1);
    end
    arvalid = 1'b0;
    arready = 1'b0;
    m_ovf = 1'b1;
    check("ovf_flag", 32'(ovf_err), 32'd1);
    serve("q0", 1, 2, -1, 1, 2'b00);
    for (int i = 0; i < 4; i++) serve("qn", i, i + 1, -1, i, 2'b00);
    check_all("queue");
    check("queue_beats_abs", beat_cnt, 32'd12);

    // slave error response plus address wrap
    pulse_clr();
    issue_ar(32'hFFFF_FFFC, 1);
    serve("wrap", 1, 2, -1, 1, 2'b10);
    check_all("wrap");
    check("wrap_errs_abs", 32'(err_cnt), 32'd0);

    // asynchronous reset mid-burst
    issue_ar(32'h8300_0000, 3);
    wait_rready("rstmid", ok);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_rready", 32'(rready), 32'd0);
    check("rstmid_idle", 32'(idle), 32'd1);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all("postrst");

    // error then clear
    issue_ar(32'h8400_0000, 0);
    serve("pre_clr", 0, 1, 0, 0, 2'b10);
    check_all("pre_clr");
    pulse_clr();
    check_all("clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
